// File: rtl/line_buf_pkg.sv
// Shared helpers for the multi-bank line buffer.
//   clog2    : ceiling log2 for constant sizing
//   bank_w   : bank pointer width, at least one bit
//   ring_inc : bank pointer increment, wraps from n-1 back to 0
package line_buf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int bank_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Bank counts need not be powers of two, so the wrap is explicit.
  function automatic int ring_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/multi_bank_line_buffer_sdp_ram.sv
// Simple dual-port RAM with a single clock and a registered read port.
//   clk, rst_n     : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates the cycle after re and holds otherwise
module sdp_ram_1clk #(
  parameter int DATA_W = 8,
  parameter int AW     = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are never cleared; only the output register sees reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multi_bank_line_buffer.sv
// N-bank ring of line buffers between a line producer and a line consumer.
// The writer fills the bank at wr_ptr and hands it over with wr_commit; the
// reader drains the bank at rd_ptr and frees it with rd_release.
//   clk, reset_n                    : clock, async active-low reset
//   wr_en/wr_addr/wr_data           : pixel write into current write bank
//   wr_commit/wr_len                : close the current line and record its length
//   wr_ready                        : a free bank exists for the writer
//   rd_en/rd_addr                   : pixel read from current read bank
//   rd_data/rd_valid                : registered read data and its strobe
//   rd_release                      : consumer done with current read bank
//   rd_bank_valid/rd_len            : committed line present and its length
//   count                           : committed banks held
//   overflow                        : one-cycle pulse on a rejected write or commit
module multi_bank_line_buffer
  import line_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int NUM_BANKS = 2,
  localparam int BANK_W   = bank_w(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic [ADDR_W:0]   wr_len,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_bank_valid,
  output logic [ADDR_W:0]   rd_len,
  output logic [BANK_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [BANK_W-1:0]                r_wr_ptr, r_rd_ptr;
  logic [BANK_W:0]                  r_count;
  logic [NUM_BANKS-1:0][ADDR_W:0]   r_len;
  logic                             r_rd_valid, r_overflow;

  logic w_wr_acc, w_rd_acc, w_commit_acc, w_rel_acc;

  // Both flags come from the registered count, so a release in the same
  // cycle cannot make room for a commit.
  assign wr_ready      = (r_count < (BANK_W+1)'(NUM_BANKS));
  assign rd_bank_valid = (r_count != '0);

  assign w_wr_acc     = wr_en      & wr_ready;
  assign w_commit_acc = wr_commit  & wr_ready;
  assign w_rd_acc     = rd_en      & rd_bank_valid;
  assign w_rel_acc    = rd_release & rd_bank_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_overflow <= (wr_en | wr_commit) & ~wr_ready;
      if (w_commit_acc) begin
        r_len[r_wr_ptr] <= wr_len;
        r_wr_ptr        <= BANK_W'(ring_inc(int'(r_wr_ptr), NUM_BANKS));
      end
      if (w_rel_acc)
        r_rd_ptr <= BANK_W'(ring_inc(int'(r_rd_ptr), NUM_BANKS));
      case ({w_commit_acc, w_rel_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Address is {bank, word}, i.e. bank*DEPTH + word; pointers never exceed
  // NUM_BANKS-1 so the index stays inside the array.
  sdp_ram_1clk #(
    .DATA_W (DATA_W),
    .AW     (BANK_W + ADDR_W),
    .DEPTH  (NUM_BANKS * DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (w_wr_acc),
    .waddr ({r_wr_ptr, wr_addr}),
    .wdata (wr_data),
    .re    (w_rd_acc),
    .raddr ({r_rd_ptr, rd_addr}),
    .rdata (rd_data)
  );

  assign rd_valid = r_rd_valid;
  assign overflow = r_overflow;
  assign count    = r_count;
  assign rd_len   = r_len[r_rd_ptr];

endmodule

// File: tb/tb_multi_bank_line_buffer.sv
module tb_multi_bank_line_buffer;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NB     = 3;
  localparam int BW     = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en, wr_commit, rd_en, rd_release;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_len;
  logic              wr_ready, rd_valid, rd_bank_valid, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   rd_len;
  logic [BW:0]       count;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_last;

  always #5 clk = ~clk;

  multi_bank_line_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_len(wr_len), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .rd_bank_valid(rd_bank_valid), .rd_len(rd_len),
    .count(count), .overflow(overflow)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    wr_addr = '0; wr_data = '0; wr_len = '0; rd_addr = '0;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d); tick(); idle_in();
  endtask

  task automatic commit(input int len);
    wr_commit = 1; wr_len = (ADDR_W+1)'(len); tick(); idle_in();
  endtask

  task automatic release_bank();
    rd_release = 1; tick(); idle_in();
  endtask

  task automatic do_reset();
    idle_in(); reset_n = 0; tick(); tick(); reset_n = 1; tick();
  endtask

  task automatic test_reset();
    idle_in(); reset_n = 0; #2;
    total++; if (count !== 0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_bank_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_bank_valid got=%b exp=0", rd_bank_valid); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%0h exp=0", rd_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (rd_len !== 0) begin bad++; $display("FAIL rst_rd_len got=%0d exp=0", rd_len); end
    tick(); reset_n = 1; tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) wr(i, 8'h10 + i);
    commit(4);
    total++; if (count !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
    total++; if (rd_bank_valid !== 1'b1) begin bad++; $display("FAIL basic_bank_valid got=%b exp=1", rd_bank_valid); end
    total++; if (rd_len !== 4) begin bad++; $display("FAIL basic_rd_len got=%0d exp=4", rd_len); end
    rd_en = 1; rd_addr = 2; tick(); idle_in();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h12) begin bad++; $display("FAIL basic_read got=%b/%0h exp=1/12", rd_valid, rd_data); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h12) begin bad++; $display("FAIL basic_read_end got=%b/%0h exp=0/12", rd_valid, rd_data); end
    release_bank();
    total++; if (count !== 0) begin bad++; $display("FAIL basic_release got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin wr(0, 8'hA0 + i); commit(5 + i); end
    total++; if (count !== 3 || wr_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=3/0", count, wr_ready); end
    total++; if (rd_len !== 5) begin bad++; $display("FAIL full_rd_len got=%0d exp=5", rd_len); end
    wr(0, 8'hEE);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_wr_ovf got=%b exp=1", overflow); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_pulse got=%b exp=0", overflow); end
    commit(9);
    total++; if (overflow !== 1'b1 || count !== 3) begin bad++; $display("FAIL full_commit_ovf got=%b/%0d exp=1/3", overflow, count); end
    rd_en = 1; rd_addr = 0; tick(); idle_in();
    total++; if (rd_data !== 8'hA0) begin bad++; $display("FAIL full_dropped_write got=%0h exp=a0", rd_data); end
    release_bank();
    total++; if (wr_ready !== 1'b1 || count !== 2) begin bad++; $display("FAIL full_release got=%b/%0d exp=1/2", wr_ready, count); end
    total++; if (rd_len !== 6) begin bad++; $display("FAIL full_rd_len2 got=%0d exp=6", rd_len); end
    release_bank(); release_bank();
    total++; if (count !== 0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      wr(0, i); commit(i + 1);
      total++; if (rd_len !== ADDR_W'(i + 1)) begin bad++; $display("FAIL wrap_len[%0d] got=%0d exp=%0d", i, rd_len, i + 1); end
      rd_en = 1; rd_addr = 0; tick(); idle_in();
      total++; if (rd_data !== DATA_W'(i)) begin bad++; $display("FAIL wrap_data[%0d] got=%0h exp=%0h", i, rd_data, i); end
      release_bank();
    end
    total++; if (count !== 0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", count); end
  endtask

  task automatic test_zero_len();
    commit(0);
    total++; if (count !== 1 || rd_len !== 0) begin bad++; $display("FAIL zlen got=%0d/%0d exp=1/0", count, rd_len); end
    release_bank();
    total++; if (count !== 0) begin bad++; $display("FAIL zlen_release got=%0d exp=0", count); end
  endtask

  task automatic test_simul();
    // write and commit together: write lands in the bank being closed
    wr_en = 1; wr_addr = 0; wr_data = 8'h55; wr_commit = 1; wr_len = 3; tick(); idle_in();
    total++; if (count !== 1 || rd_len !== 3) begin bad++; $display("FAIL sim_first got=%0d/%0d exp=1/3", count, rd_len); end
    rd_en = 1; rd_addr = 0; tick(); idle_in();
    total++; if (rd_data !== 8'h55) begin bad++; $display("FAIL sim_wr_commit got=%0h exp=55", rd_data); end
    wr_en = 1; wr_addr = 0; wr_data = 8'h56; wr_commit = 1; wr_len = 9; rd_release = 1; tick(); idle_in();
    total++; if (count !== 1 || rd_len !== 9) begin bad++; $display("FAIL sim_cr got=%0d/%0d exp=1/9", count, rd_len); end
    rd_en = 1; rd_addr = 0; tick(); idle_in();
    total++; if (rd_data !== 8'h56) begin bad++; $display("FAIL sim_cr_data got=%0h exp=56", rd_data); end
    wr(0, 8'h57); commit(10); wr(0, 8'h58); commit(11);
    total++; if (count !== 3) begin bad++; $display("FAIL sim_fill got=%0d exp=3", count); end
    wr_commit = 1; wr_len = 12; rd_release = 1; tick(); idle_in();
    total++; if (overflow !== 1'b1 || count !== 2) begin bad++; $display("FAIL sim_full_cr got=%b/%0d exp=1/2", overflow, count); end
    total++; if (rd_len !== 10) begin bad++; $display("FAIL sim_full_len got=%0d exp=10", rd_len); end
    rd_en = 1; rd_addr = 0; tick(); idle_in();
    total++; if (rd_data !== 8'h57) begin bad++; $display("FAIL sim_full_data got=%0h exp=57", rd_data); end
    release_bank(); release_bank();
    total++; if (count !== 0) begin bad++; $display("FAIL sim_drain got=%0d exp=0", count); end
  endtask

  task automatic test_rd_release_same();
    wr(0, 8'h61); commit(1); wr(0, 8'h62); commit(1);
    rd_en = 1; rd_addr = 0; rd_release = 1; tick(); idle_in();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h61 || count !== 1) begin bad++; $display("FAIL rdrel got=%b/%0h/%0d exp=1/61/1", rd_valid, rd_data, count); end
    rd_en = 1; rd_addr = 0; tick(); idle_in();
    total++; if (rd_data !== 8'h62) begin bad++; $display("FAIL rdrel_next got=%0h exp=62", rd_data); end
    exp_last = 8'h62;
    release_bank();
  endtask

  task automatic test_empty();
    rd_en = 1; rd_addr = 3; tick(); idle_in();
    total++; if (rd_valid !== 1'b0 || rd_data !== exp_last) begin bad++; $display("FAIL empty_read got=%b/%0h exp=0/%0h", rd_valid, rd_data, exp_last); end
    release_bank();
    total++; if (count !== 0 || overflow !== 1'b0) begin bad++; $display("FAIL empty_release got=%0d/%b exp=0/0", count, overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(3, 8'hB0); commit(4); wr(3, 8'hB1); commit(4);
    wr(3, 8'hB2);
    rd_en = 1; rd_addr = 3; tick(); idle_in();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hB0) begin bad++; $display("FAIL rmid_pre got=%b/%0h exp=1/b0", rd_valid, rd_data); end
    reset_n = 0; #1;
    total++; if (count !== 0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_async got=%0d/%b/%0h/%b exp=0/0/0/1", count, rd_valid, rd_data, wr_ready); end
    tick(); reset_n = 1; tick();
    commit(2);
    total++; if (count !== 1 || rd_len !== 2) begin bad++; $display("FAIL rmid_commit got=%0d/%0d exp=1/2", count, rd_len); end
    rd_en = 1; rd_addr = 3; tick(); idle_in();
    total++; if (rd_data !== 8'hB0) begin bad++; $display("FAIL rmid_bank0 got=%0h exp=b0", rd_data); end
  endtask

  initial begin
    idle_in(); reset_n = 0; exp_last = '0;
    #12;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_zero_len();
    test_simul();
    test_rd_release_same();
    test_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
